// File: rtl/lathe_panel_if.sv
// rtl/lathe_panel_if.sv - operator panel input conditioning and start/mode/e-stop interlock
// Each raw contact is synchronized and debounced before the sealed-in start FSM sees it.

module lathe_panel_db #(
  parameter int   DB_CYCLES = 1000000,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronized level disagrees with the filtered one.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      deb_q   <= RST_VAL;
      cnt_q   <= '0;
    end else if (ena) begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = deb_q;
endmodule

module lathe_panel_if #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       start_pb,
  input  logic       stop_pb,
  input  logic       estop_n,
  input  logic       sel_auto,
  input  logic       sel_man,
  input  logic       control_fb,
  output logic       start_o,
  output logic       auto_o,
  output logic       man_o,
  output logic       fault,
  output logic       run_lamp,
  output logic [1:0] state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  logic db_start, db_stop, db_estop_n, db_auto, db_man;

  lathe_panel_db #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_start (
    .clk(clk), .reset(reset), .ena(ena), .din(start_pb), .dout(db_start)
  );
  lathe_panel_db #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_stop (
    .clk(clk), .reset(reset), .ena(ena), .din(stop_pb), .dout(db_stop)
  );
  lathe_panel_db #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_estop (
    .clk(clk), .reset(reset), .ena(ena), .din(estop_n), .dout(db_estop_n)
  );
  lathe_panel_db #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_auto (
    .clk(clk), .reset(reset), .ena(ena), .din(sel_auto), .dout(db_auto)
  );
  lathe_panel_db #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_man (
    .clk(clk), .reset(reset), .ena(ena), .din(sel_man), .dout(db_man)
  );

  state_t state_q, state_d;
  logic   start_q, start_d;
  logic   auto_q, auto_d;
  logic   man_q, man_d;
  logic   fault_q, fault_d;
  logic   run_lamp_q, run_lamp_d;
  logic   start_prev_q, start_prev_d;

  logic start_rise, mode_ok, mode_chg;

  assign start_rise = db_start & ~start_prev_q;
  assign mode_ok    = db_auto ^ db_man;
  // auto_q/man_q double as the latched mode: they are only nonzero in RUN.
  assign mode_chg   = ({db_auto, db_man} != {auto_q, man_q});

  always_comb begin
    state_d      = state_q;
    auto_d       = auto_q;
    man_d        = man_q;
    start_prev_d = db_start;
    run_lamp_d   = start_q & control_fb;
    case (state_q)
      S_IDLE: begin
        if (!db_estop_n || (db_auto && db_man)) begin
          state_d = S_FAULT;
        end else if (start_rise && mode_ok && !db_stop) begin
          state_d = S_RUN;
          auto_d  = db_auto;
          man_d   = db_man;
        end
      end
      S_RUN: begin
        if (!db_estop_n) begin
          state_d = S_FAULT;
        end else if (db_stop || mode_chg) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (db_estop_n && !db_start && db_stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != S_RUN) begin
      auto_d = 1'b0;
      man_d  = 1'b0;
    end
    start_d = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      auto_q       <= 1'b0;
      man_q        <= 1'b0;
      fault_q      <= 1'b0;
      run_lamp_q   <= 1'b0;
      start_prev_q <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      start_q      <= start_d;
      auto_q       <= auto_d;
      man_q        <= man_d;
      fault_q      <= fault_d;
      run_lamp_q   <= run_lamp_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign start_o  = start_q;
  assign auto_o   = auto_q;
  assign man_o    = man_q;
  assign fault    = fault_q;
  assign run_lamp = run_lamp_q;
  assign state    = state_q;
endmodule

// File: doc/lathe_panel_if.md
Name: lathe_panel_if

Overview:
Operator-panel front end for the lathe controller. It synchronizes and debounces the raw panel inputs: start and stop pushbuttons, emergency stop, and the AUTO/MAN selector. It turns the momentary start button into a sealed-in start level and enforces mode and e-stop interlocks. Its outputs start_o, auto_o and man_o drive the start/AUTO/MAN inputs of the spindle control block, and control_fb returns that block's Control output for the run lamp.

Parameters:
DB_CYCLES, 1000000, debounce window in clk cycles (20 ms at 50 MHz); bench uses 4; legal range ≥ 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ena  input  1  clock enable; when low, every register holds its value
start_pb  input  1  raw start pushbutton, 1 = pressed, asynchronous
stop_pb  input  1  raw stop pushbutton, 1 = pressed, asynchronous
estop_n  input  1  raw emergency stop, 0 = e-stop active, asynchronous
sel_auto  input  1  raw selector AUTO contact
sel_man  input  1  raw selector MAN contact
control_fb  input  1  Control output of the spindle control block
start_o  output  1  sealed-in start request
auto_o  output  1  latched AUTO mode, valid in RUN
man_o  output  1  latched MAN mode, valid in RUN
fault  output  1  1 while in FAULT
run_lamp  output  1  registered start_o & control_fb
state  output  2  00 IDLE, 01 RUN, 10 FAULT

Behaviour:
- Reset values: all outputs 0, state IDLE; latched mode 0.
  - Reset values of internal filters: sync flops and debounced values 0, except the estop_n path, whose sync flops and debounced value reset to 1.
- Input conditioning, per raw input:
  - 2-flop synchronizer, then a debounce filter.
  - Filter counter has width $clog2(DB_CYCLES)+1. It increments while the sync output differs from the debounced value and clears to 0 when they agree.
  - When the counter reaches DB_CYCLES-1 while differing, the debounced value takes the sync value and the counter clears.
  - Latency: a raw level stable from edge k appears at the debounced value at edge k+2+DB_CYCLES. A glitch shorter than DB_CYCLES cycles is rejected.
- Derived signals:
  - start_rise is a 1-cycle pulse on a 0→1 of debounced start.
  - mode_ok = exactly one of debounced auto/man is 1.
- FSM (registered; outputs change one edge after the debounced event). Priority when events coincide: e-stop > stop > mode change > start.
  - IDLE → FAULT: debounced estop_n = 0, or both debounced auto and man = 1.
  - IDLE → RUN: start_rise & mode_ok & stop = 0. On entry, latch mode (auto_o/man_o from debounced selector).
  - IDLE otherwise: stay.
  - RUN → FAULT: debounced estop_n = 0.
  - RUN → IDLE: stop = 1, or debounced selector differs from latched mode (includes both-on or both-off).
  - RUN otherwise: stay; start_o stays 1 even after the start button is released (seal-in).
  - FAULT → IDLE only when all hold in the same cycle: debounced estop_n = 1, start = 0, stop = 1 (acknowledge). Otherwise stay.
- Output decoding:
  - start_o = (state == RUN).
  - auto_o and man_o = latched mode in RUN; 0 in IDLE and FAULT.
  - fault = (state == FAULT).
  - run_lamp is registered from start_o & control_fb, so it lags by 1 cycle.
  - Latched mode clears on leaving RUN.
- Start held through IDLE entry (no new rising edge) never restarts; the operator must release and press again.
- ena low: the sync, debounce and FSM registers all freeze; no counter advance.
- Reset mid-RUN: outputs drop to 0 asynchronously; the block returns to IDLE with no restart.

Test Plan:
- DB_CYCLES=4; sel_man=1 stable; pulse start_pb high for 10 cycles starting edge 20 → start_o=1 and man_o=1 at edge 27. start_o stays 1 after release; state=01.
- From RUN, raise stop_pb for 8 cycles → start_o=0, man_o=0 at 7 edges after press. Releasing stop with start_pb still held → no restart.
- Start_pb glitch of 3 cycles with sel_auto=1 → state remains IDLE, start_o=0.
- In RUN (AUTO): estop_n=0 and stop_pb=1 raised on the same edge → state=10, fault=1, start_o=0. Then release estop and hold stop with start=0 → state returns to 00.
- sel_auto=1 and sel_man=1 both set in IDLE → FAULT. Flip the selector AUTO→MAN in RUN → IDLE, no fault.
- ena=0 for 20 cycles during a start press → no state change. control_fb=1 in RUN → run_lamp=1 one cycle later. Assert reset mid-RUN → all outputs 0 immediately.
